demux_1_4_stream: RTL

Registered 1-to-4 stream demultiplexer: the distribution counterpart of the 4:1 data muxes. It accepts one valid/ready stream carrying a 2-bit lane select and routes each beat to one of four independent downstream valid/ready outputs. Each lane has a two-entry skid buffer, so a stalled lane never blocks the others and every lane sustains one beat per cycle. It sits wherever one producer feeds four consumers, for example request fan-out to four units.

---
 rtl/demux_pkg.sv | 13 +
 rtl/stream_skid_2.sv | 69 ++++++
 rtl/demux_1_4_stream.sv | 48 ++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:4 stream demultiplexer.
package demux_pkg;

  localparam int unsigned N_LANES = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } lane_state_t;

endpackage : demux_pkg

// File: rtl/stream_skid_2.sv
// One output lane: two-entry FIFO (main + skid) with a valid/ready handshake
// on both sides. out_data always reflects the main register.
module stream_skid_2
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  lane_state_t      r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;

  // Handshake qualifiers for this lane.
  always_comb begin
    w_push = in_valid && in_ready;
    w_pop  = out_valid && out_ready;
  end

  // Lane occupancy FSM and storage; reset clears both data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_main  <= in_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_main <= in_data;
          end else if (w_push) begin
            r_skid  <= in_data;
            r_state <= TWO;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule : stream_skid_2

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demultiplexer. Each beat is routed by up_sel to one
// of four independent lanes, each buffered by a two-entry skid FIFO.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            up_valid,
  output logic                            up_ready,
  input  logic [WIDTH-1:0]                up_data,
  input  logic [SEL_W-1:0]                up_sel,
  output logic [N_LANES-1:0]              dn_valid,
  input  logic [N_LANES-1:0]              dn_ready,
  output logic [N_LANES-1:0][WIDTH-1:0]   dn_data
);

  logic [N_LANES-1:0] w_lane_ready;
  logic [N_LANES-1:0] w_push;

  // up_ready depends only on the selected lane's registered state and rst.
  assign up_ready = !rst && w_lane_ready[up_sel];

  // Select decode: at most one lane sees a push per cycle.
  always_comb begin
    w_push = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      w_push[i] = up_valid && up_ready && (up_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    stream_skid_2 #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_push[g]),
      .in_ready  (w_lane_ready[g]),
      .in_data   (up_data),
      .out_valid (dn_valid[g]),
      .out_ready (dn_ready[g]),
      .out_data  (dn_data[g])
    );
  end

endmodule : demux_1_4_stream
